// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension unit: mode codes,
// mode field width and the skid-buffer occupancy states.
package imm_ext_pkg;

  localparam int IMM_MODE_W = 3;

  localparam logic [IMM_MODE_W-1:0] IMM_MODE_ZERO   = 3'd0;
  localparam logic [IMM_MODE_W-1:0] IMM_MODE_SIGN   = 3'd1;
  localparam logic [IMM_MODE_W-1:0] IMM_MODE_LUI    = 3'd2;
  localparam logic [IMM_MODE_W-1:0] IMM_MODE_BRANCH = 3'd3;

  // Occupancy of the 2-entry output buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender. Produces the DATA_W-bit operand and an
// illegal-mode flag from a raw immediate and a 3-bit mode code.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IMM_W   = 16,
  parameter int DATA_W  = 32,
  parameter int SHIFT_B = 2
) (
  input  logic [IMM_W-1:0]      in_imm,
  input  logic [IMM_MODE_W-1:0] in_mode,
  output logic [DATA_W-1:0]     data,
  output logic                  err
);

  logic signed [DATA_W-1:0] sext;
  logic        [DATA_W-1:0] zext;
  logic        [DATA_W-1:0] upper;

  assign sext  = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  assign zext  = {{(DATA_W-IMM_W){1'b0}}, in_imm};
  assign upper = {in_imm, {(DATA_W-IMM_W){1'b0}}};

  // Select the extension; any unassigned mode returns zero with err set.
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (in_mode)
      IMM_MODE_ZERO:   data = zext;
      IMM_MODE_SIGN:   data = sext;
      IMM_MODE_LUI:    data = upper;
      IMM_MODE_BRANCH: data = sext <<< SHIFT_B;
      default:         err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage with a 2-entry skid buffer.
// Extension is done at the input; the buffered result, error flag and tag
// are presented through a valid/ready output. in_ready comes from a flop.
// Optional feature macro IMM_EXT_PERF_EN adds perf_cnt (output transfers,
// wrapping) and perf_err (output transfers with out_err, saturating).
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IMM_W   = 16,
  parameter int DATA_W  = 32,
  parameter int SHIFT_B = 2,
  parameter int TAG_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IMM_W-1:0]      in_imm,
  input  logic [IMM_MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_err,
  output logic [TAG_W-1:0]      out_tag
`ifdef IMM_EXT_PERF_EN
  ,
  output logic [31:0]           perf_cnt,
  output logic [15:0]           perf_err
`endif
);

  // ---- stage p0: combinational extension of the incoming beat ----
  logic [DATA_W-1:0] ext_data_p0;
  logic              ext_err_p0;

  imm_ext_core #(
    .IMM_W   (IMM_W),
    .DATA_W  (DATA_W),
    .SHIFT_B (SHIFT_B)
  ) u_core (
    .in_imm  (in_imm),
    .in_mode (in_mode),
    .data    (ext_data_p0),
    .err     (ext_err_p0)
  );

  // ---- stage p1: main and skid registers ----
  buf_state_t        state, next_state;
  logic              rdy;
  logic              in_xfer, out_xfer;
  logic              load_main_in, load_main_skid, load_skid;

  logic [DATA_W-1:0] main_data_p1, skid_data_p1;
  logic              main_err_p1,  skid_err_p1;
  logic [TAG_W-1:0]  main_tag_p1,  skid_tag_p1;

  assign in_ready  = rdy;
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_data_p1;
  assign out_err   = main_err_p1;
  assign out_tag   = main_tag_p1;

  assign in_xfer  = in_valid && rdy;
  assign out_xfer = out_valid && out_ready;

  // Buffer occupancy transitions and register load selects.
  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_xfer) begin
          load_main_in = 1'b1;
          next_state   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          load_skid  = 1'b1;
          next_state = ST_TWO;
        end else if (out_xfer) begin
          next_state = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          load_main_skid = 1'b1;
          next_state     = ST_ONE;
        end
      end
      default: next_state = ST_EMPTY;
    endcase
  end

  // State and registered ready; reset and flush both return to EMPTY.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state <= ST_EMPTY;
      rdy   <= 1'b1;
    end else begin
      state <= next_state;
      rdy   <= (next_state != ST_TWO);
    end
  end

  // Main/skid payload; cleared on reset and flush so outputs read zero.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      main_data_p1 <= '0;
      main_err_p1  <= 1'b0;
      main_tag_p1  <= '0;
      skid_data_p1 <= '0;
      skid_err_p1  <= 1'b0;
      skid_tag_p1  <= '0;
    end else begin
      if (load_main_in) begin
        main_data_p1 <= ext_data_p0;
        main_err_p1  <= ext_err_p0;
        main_tag_p1  <= in_tag;
      end else if (load_main_skid) begin
        main_data_p1 <= skid_data_p1;
        main_err_p1  <= skid_err_p1;
        main_tag_p1  <= skid_tag_p1;
      end
      if (load_skid) begin
        skid_data_p1 <= ext_data_p0;
        skid_err_p1  <= ext_err_p0;
        skid_tag_p1  <= in_tag;
      end
    end
  end

`ifdef IMM_EXT_PERF_EN
  // Transfer counters; flush suppresses the transfer but keeps the counts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cnt <= '0;
      perf_err <= '0;
    end else if (out_xfer && !flush) begin
      perf_cnt <= perf_cnt + 32'd1;
      if (main_err_p1 && (perf_err != 16'hFFFF))
        perf_err <= perf_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: the driver pushes the expected beat
// when it offers an accepted input, a negedge monitor pops and compares on
// every output transfer.
module tb_imm_ext_pipe;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [4:0]  tag;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [15:0] in_imm;
  logic [2:0]  in_mode;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] out_data;
`ifdef IMM_EXT_PERF_EN
  logic [31:0] perf_cnt;
  logic [15:0] perf_err;
  logic [31:0] perf_keep;
`endif

  int    checks = 0;
  int    errors = 0;
  int    out_seen = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  imm_ext_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_tag   (out_tag)
`ifdef IMM_EXT_PERF_EN
    ,
    .perf_cnt  (perf_cnt),
    .perf_err  (perf_err)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension for the default parameters (16 -> 32, shift 2).
  function automatic logic [32:0] model(input logic [15:0] imm, input logic [2:0] mode);
    case (mode)
      3'd0:    model = {1'b0, 16'h0000, imm};
      3'd1:    model = {1'b0, {16{imm[15]}}, imm};
      3'd2:    model = {1'b0, imm, 16'h0000};
      3'd3:    model = {1'b0, {14{imm[15]}}, imm, 2'b00};
      default: model = {1'b1, 32'h0};
    endcase
  endfunction

  // Offer one beat; returns once it has been taken at a rising edge.
  task automatic send(input logic [15:0] imm, input logic [2:0] mode, input logic [4:0] tag,
                      input logic [31:0] d, input logic e, output int waits, output logic ov);
    beat_t b;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
    waits    = 0;
    @(negedge clk);
    ov = out_valid;
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at 0 for tag %0d", tag);
    end else begin
      b.data = d; b.err = e; b.tag = tag;
      sb.push_back(b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output transfer must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      out_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: data 0x%0h tag %0d with empty scoreboard", out_data, out_tag);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("out_err",  64'(out_err),  64'(e.err));
        chk("out_tag",  64'(out_tag),  64'(e.tag));
      end
    end
  end

  initial begin
    int          w;
    logic        ov;
    logic [32:0] m;
    int          seen0;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_imm = 16'hFFFF; in_mode = 3'd1; in_tag = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    chk("reset_out_data",  64'(out_data),  64'd0);
    chk("reset_out_tag",   64'(out_tag),   64'd0);
`ifdef IMM_EXT_PERF_EN
    chk("reset_perf_cnt",  64'(perf_cnt),  64'd0);
`endif
    @(posedge clk); #1;

    // Extension values, one-cycle latency.
    send(16'h8001, 3'd0, 5'd1, 32'h0000_8001, 1'b0, w, ov);
    in_valid = 1'b0; @(negedge clk); chk("lat_zero", 64'(out_valid), 64'd1); @(posedge clk); #1;
    send(16'h8001, 3'd1, 5'd2, 32'hFFFF_8001, 1'b0, w, ov);
    in_valid = 1'b0; @(negedge clk); chk("lat_sign", 64'(out_valid), 64'd1); @(posedge clk); #1;
    send(16'h8001, 3'd2, 5'd3, 32'h8001_0000, 1'b0, w, ov);
    in_valid = 1'b0; @(negedge clk); chk("lat_lui", 64'(out_valid), 64'd1); @(posedge clk); #1;
    send(16'h8001, 3'd3, 5'd4, 32'hFFFE_0004, 1'b0, w, ov);
    in_valid = 1'b0; @(negedge clk); chk("lat_branch", 64'(out_valid), 64'd1); @(posedge clk); #1;
    send(16'h7FFF, 3'd3, 5'd5, 32'h0001_FFFC, 1'b0, w, ov);
    idle_cycle();

    // Illegal mode.
    send(16'h1234, 3'd5, 5'd7, 32'h0, 1'b1, w, ov);
    in_valid = 1'b0; @(negedge clk); chk("illegal_valid", 64'(out_valid), 64'd1); @(posedge clk); #1;
`ifdef IMM_EXT_PERF_EN
    chk("perf_err_one", 64'(perf_err), 64'd1);
`endif
    idle_cycle();

    // Backpressure: two accepted, third refused.
    out_ready = 1'b0;
    send(16'h00AA, 3'd0, 5'd10, 32'h0000_00AA, 1'b0, w, ov);
    send(16'hFF00, 3'd1, 5'd11, 32'hFFFF_FF00, 1'b0, w, ov);
    in_imm = 16'h0BAD; in_tag = 5'd12;
    @(negedge clk);
    chk("bp_third_refused", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("bp_held_tag", 64'(out_tag), 64'd10);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_first_valid", 64'(out_valid), 64'd1);
    chk("bp_ready_still0", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("bp_no_gap", 64'(out_valid), 64'd1);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    idle_cycle();

    // Streaming 100 beats.
    seen0 = out_seen;
    for (int i = 0; i < 100; i++) begin
      logic [15:0] imm;
      logic [2:0]  mode;
      imm  = 16'(i * 16'h0123 + 16'h8000 * (i % 2));
      mode = 3'(i % 4);
      m    = model(imm, mode);
      send(imm, mode, 5'(i), m[31:0], m[32], w, ov);
      chk("stream_ready", 64'(w), 64'd0);
      if (i > 0) chk("stream_out_valid", 64'(ov), 64'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    idle_cycle();
    chk("stream_count", 64'(out_seen - seen0), 64'd100);

    // Flush in TWO with an input presented.
    out_ready = 1'b0;
    send(16'h0001, 3'd0, 5'd20, 32'h1, 1'b0, w, ov);
    send(16'h0002, 3'd0, 5'd21, 32'h2, 1'b0, w, ov);
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_pre_two", 64'(in_ready), 64'd0);
`ifdef IMM_EXT_PERF_EN
    perf_keep = perf_cnt;
`endif
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_imm = 16'h0003; in_tag = 5'd22; out_ready = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready",  64'(in_ready),  64'd1);
    chk("flush_out_data",  64'(out_data),  64'd0);
`ifdef IMM_EXT_PERF_EN
    chk("flush_perf_keep", 64'(perf_cnt), 64'(perf_keep));
`endif
    @(posedge clk); #1;
    idle_cycle(); idle_cycle();
    send(16'h4321, 3'd2, 5'd23, 32'h4321_0000, 1'b0, w, ov);
    idle_cycle(); idle_cycle();

    // Reset mid-stream while out_valid is high.
    out_ready = 1'b0;
    send(16'hBEEF, 3'd1, 5'd24, 32'hFFFF_BEEF, 1'b0, w, ov);
    in_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_out_data",  64'(out_data),  64'd0);
    chk("rst2_out_err",   64'(out_err),   64'd0);
    chk("rst2_out_tag",   64'(out_tag),   64'd0);
    chk("rst2_in_ready",  64'(in_ready),  64'd1);
`ifdef IMM_EXT_PERF_EN
    chk("rst2_perf_cnt",  64'(perf_cnt),  64'd0);
`endif
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'h0010, 3'd3, 5'd25, 32'h0000_0040, 1'b0, w, ov);
    in_valid = 1'b0;

    // Drain with a bound.
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
Registered, parametrised immediate-extension unit for the decode stage of the pipelined CPU. It accepts an immediate, a mode and a tag through a valid/ready handshake. It produces the extended DATA_W-bit operand one cycle later through a 2-entry skid buffer, so in_ready is a register output. It adds a branch-offset mode, illegal-mode flagging, tag passthrough and pipeline flush.

Parameters:
IMM_W, 16, immediate field width
DATA_W, 32, extended operand width; must be greater than IMM_W+SHIFT_B
SHIFT_B, 2, left shift applied in BRANCH mode
TAG_W, 5, width of the sideband tag carried with each beat

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
flush  in  1  synchronous pipeline flush; drops all buffered beats
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept a beat
in_imm  in  IMM_W  raw immediate
in_mode  in  3  extension mode (see Behaviour)
in_tag  in  TAG_W  sideband tag, passed through unchanged
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts the beat
out_data  out  DATA_W  extended operand
out_err  out  1  beat carried an illegal mode
out_tag  out  TAG_W  tag of the output beat

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled at the clk rising edge.
- Modes:
  - 0 ZERO: zero-extend in_imm.
  - 1 SIGN: sign-extend in_imm.
  - 2 LUI: in_imm in the top IMM_W bits, zeros below.
  - 3 BRANCH: sign-extend in_imm, then shift left by SHIFT_B; bits shifted out are discarded.
  - 4..7 illegal: out_data=0, out_err=1.
  - Legal modes always give out_err=0.
- Extension is computed combinationally at the input and registered on acceptance. Only in_imm, in_mode and in_tag are captured; extension is never redone at the output.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- in_ready = !skid_valid, driven directly from a flop. out_valid = main_valid.
- Buffer states:
  - EMPTY (main and skid empty): an input transfer goes to main.
  - ONE (main full): input transfer and output transfer together: new beat replaces main. Input transfer only: new beat goes to skid, move to TWO. Output transfer only: move to EMPTY.
  - TWO (main and skid full): in_ready=0. Output transfer moves skid into main, move to ONE.
- Latency: an accepted beat is visible on out_* at the next rising edge when the buffer was EMPTY, or was ONE with an output transfer in the same cycle.
- Throughput: one beat per cycle while out_ready stays high.
- Ordering: strict FIFO; no beat is dropped or duplicated except on flush or reset.
- out_* hold stable while out_valid && !out_ready.
- Reset (rst_n low at the edge):
  - State EMPTY; out_valid=0, out_data=0, out_err=0, out_tag=0, skid cleared.
  - in_ready reads 1 from the first edge after reset.
  - in_valid is ignored while rst_n is low.
- Flush (rst_n high, flush high at the edge):
  - Same register effect as reset; any beat presented in that cycle is dropped.
  - in_ready is 1 in the following cycle.
- Reset has priority over flush. Flush has priority over any transfer.

Optional Feature:
Macro IMM_EXT_PERF_EN.
- Defined:
  - Adds output port perf_cnt, 32 bits, counting output transfers.
  - Resets to 0 on rst_n low; flush does not clear it.
  - Wraps from 0xFFFFFFFF to 0.
  - Also adds output port perf_err, 16 bits, counting output transfers with out_err=1; saturates at 0xFFFF.
- Undefined: neither port nor either counter exists, and the rest of the behaviour is identical.

Decomposition:
- Shared package imm_ext_pkg holds the mode codes (IMM_MODE_ZERO=0, IMM_MODE_SIGN=1, IMM_MODE_LUI=2, IMM_MODE_BRANCH=3) and the mode width constant (3).
- One sub-module, imm_ext_core: purely combinational; in_imm and in_mode in, data and err out; parametrised by IMM_W, DATA_W, SHIFT_B.
- The top level holds the skid buffer, the state and the optional counters.

Test Plan:
- Extension values: with out_ready=1, beats (0x8001, mode 0/1/2/3) -> out_data 0x00008001, 0xFFFF8001, 0x80010000, 0xFFFE0004, each one cycle after acceptance; out_err=0.
- Illegal mode: in_mode=5, imm 0x1234, tag 7 -> out_data=0, out_err=1, out_tag=7.
- Backpressure: out_ready=0, three back-to-back beats -> first two accepted and in_ready=0 on the third. Release out_ready -> beats emerge in order with tags intact and no gap; in_ready returns to 1 one cycle after the first output transfer.
- Streaming: 100 consecutive beats with out_ready=1 -> 100 output transfers in 100 consecutive cycles; in_ready never drops.
- Flush in TWO state while in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed beats and the dropped input never appear.
- Reset mid-stream (rst_n low for 1 cycle with out_valid=1) -> all outputs zero and state EMPTY. With IMM_EXT_PERF_EN: perf_cnt=0 after reset, but unchanged after a flush.
